vga_timing: RTL

Generates the 800x480 VGA raster for the 8-bit computer's debug display.
- Free-running horizontal and vertical counters drive the `vga_h`/`vga_v` request coordinates into the frame renderer.
- The renderer returns an RGB pixel a fixed number of cycles later. This block delays its own sync and data-enable pipeline by the same amount, so colour, syncs and blanking leave the chip aligned.
- It sits between the pixel clock domain's top level and the frame renderer, and is the only source of raster timing.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_timing.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared raster constants for the debug display: default 800x480 timing and
// the coordinate/colour widths that the timing block and the renderer agree on.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 24;

  localparam int H_ACTIVE_D = 800;
  localparam int H_FP_D     = 40;
  localparam int H_SYNC_D   = 128;
  localparam int H_BP_D     = 88;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 13;
  localparam int V_SYNC_D   = 3;
  localparam int V_BP_D     = 29;

  // Raw (active-high) control bundle carried down the alignment pipeline
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vga_ctl_t;

  function automatic int span_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset and per-bit reset value;
// DEPTH of 0 degenerates to a straight wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_q = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe <= {DEPTH{RST_VAL}};
        end else begin
          r_pipe[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters feed the renderer, and the
// sync/de decode is delayed to line up with the renderer's returned pixel.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE      = H_ACTIVE_D,
  parameter int   H_FP          = H_FP_D,
  parameter int   H_SYNC        = H_SYNC_D,
  parameter int   H_BP          = H_BP_D,
  parameter int   V_ACTIVE      = V_ACTIVE_D,
  parameter int   V_FP          = V_FP_D,
  parameter int   V_SYNC        = V_SYNC_D,
  parameter int   V_BP          = V_BP_D,
  parameter logic HSYNC_POL     = 1'b0,
  parameter logic VSYNC_POL     = 1'b0,
  parameter int   PIXEL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] vga_h,
  output logic [COORD_W-1:0] vga_v,
  input  logic [RGB_W-1:0]   pixel_in,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_de,
  output logic               frame_start
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
      $fatal(1, "vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
    end
    if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 7) begin : g_bad_lat
      $fatal(1, "vga_timing: PIXEL_LATENCY must be 0..7");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] r_h, r_v;
  vga_ctl_t           w_ctl0, w_ctl_d;

  logic               r_de, r_hs, r_vs, r_fs;
  logic [RGB_W-1:0]   r_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // v only moves on the h wrap, so vsync naturally changes at h == 0
  always_comb begin
    w_ctl0    = '0;
    w_ctl0.de = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    w_ctl0.hs = (r_h >= H_HS_BEG) && (r_h < H_HS_END);
    w_ctl0.vs = (r_v >= V_VS_BEG) && (r_v < V_VS_END);
    w_ctl0.fs = (r_h == '0) && (r_v == '0);
  end

  vga_delay_line #(
    .WIDTH  ($bits(vga_ctl_t)),
    .DEPTH  (PIXEL_LATENCY),
    .RST_VAL('0)
  ) u_ctl_dly (
    .clk (clk),
    .rst (reset),
    .i_d (w_ctl0),
    .o_q (w_ctl_d)
  );

  // Polarity is applied only here so the pipeline always resets to "inactive"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_de  <= 1'b0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= w_ctl_d.de;
      r_hs  <= w_ctl_d.hs ? HSYNC_POL : ~HSYNC_POL;
      r_vs  <= w_ctl_d.vs ? VSYNC_POL : ~VSYNC_POL;
      r_fs  <= w_ctl_d.fs;
      r_rgb <= w_ctl_d.de ? pixel_in : '0;
    end
  end

  assign vga_h       = r_h;
  assign vga_v       = r_v;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign vga_hsync   = r_hs;
  assign vga_vsync   = r_vs;
  assign vga_de      = r_de;
  assign frame_start = r_fs;

endmodule
